// File: rtl/ps2_key_buffer.sv
// rtl/ps2_key_buffer.sv - PS/2 keyboard receiver feeding a scan-code FIFO read by the memory subsystem
// Make codes are queued; F0-prefixed break codes and E0 prefixes are discarded.
module ps2_key_buffer #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 2500
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       clean_key_buffer,
    output logic [7:0] pressed_key,
    output logic       overflow,
    output logic       frame_error
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt, r_filt_d;
    logic [FW-1:0] r_filt_cnt;
    state_t        r_state, w_next;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shreg;
    logic          r_par_ok;
    logic [TW-1:0] r_tcnt;
    logic          r_break;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [CW-1:0] r_count;

    logic          w_fall, w_good, w_err, w_timeout;
    logic          w_push_req, w_push, w_pop, w_full, w_drop;
    logic [AW-1:0] w_rd_next;
    logic [CW-1:0] w_cnt_next;
    logic [7:0]    w_head_next;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // A differing sample run shorter than FILTER_LEN restarts the count and is ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_filt     <= 1'b1;
            r_filt_d   <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (r_clk_s2 == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_filt     <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_fall = r_filt_d & ~r_filt;

    always_comb begin
        w_next    = r_state;
        w_good    = 1'b0;
        w_err     = 1'b0;
        w_timeout = (r_state != S_IDLE) && !w_fall && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
        if (w_timeout) begin
            w_next = S_IDLE;
            w_err  = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!r_dat_s2) w_next = S_DATA;
                S_DATA:   if (r_bitcnt == 3'd7) w_next = S_PARITY;
                S_PARITY: w_next = S_STOP;
                S_STOP: begin
                    w_next = S_IDLE;
                    if (r_dat_s2 && r_par_ok) w_good = 1'b1;
                    else                      w_err  = 1'b1;
                end
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_shreg  <= '0;
            r_par_ok <= 1'b0;
            r_tcnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_fall) begin
                case (r_state)
                    S_IDLE: r_bitcnt <= '0;
                    S_DATA: begin
                        r_shreg  <= {r_dat_s2, r_shreg[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                    S_PARITY: r_par_ok <= ^{r_shreg, r_dat_s2};
                    default: ;
                endcase
            end
            if (w_next == S_IDLE || w_fall) r_tcnt <= '0;
            else                            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_break <= 1'b0;
        end else if (w_err) begin
            r_break <= 1'b0;
        end else if (w_good) begin
            if (r_shreg == 8'hF0)      r_break <= 1'b1;
            else if (r_shreg == 8'hE0) r_break <= r_break;
            else                       r_break <= 1'b0;
        end
    end

    always_comb begin
        w_push_req = w_good && (r_shreg != 8'hF0) && (r_shreg != 8'hE0) && !r_break;
        w_full     = (r_count == CW'(FIFO_DEPTH));
        w_pop      = clean_key_buffer && (r_count != '0);
        w_push     = w_push_req && (!w_full || w_pop);
        w_drop     = w_push_req && w_full && !w_pop;
        w_rd_next  = r_rd + AW'(w_pop);
        w_cnt_next = r_count + CW'(w_push) - CW'(w_pop);
        // The entry being written this cycle is not yet in r_mem, so bypass it onto the head.
        if (w_cnt_next == '0)                       w_head_next = 8'h00;
        else if (w_push && (w_rd_next == r_wr))     w_head_next = r_shreg;
        else                                        w_head_next = r_mem[w_rd_next];
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr] <= r_shreg;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rd        <= '0;
            r_wr        <= '0;
            r_count     <= '0;
            pressed_key <= 8'h00;
            overflow    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            r_rd        <= w_rd_next;
            if (w_push) r_wr <= r_wr + 1'b1;
            r_count     <= w_cnt_next;
            pressed_key <= w_head_next;
            if (w_drop) overflow <= 1'b1;
            frame_error <= w_err;
        end
    end

endmodule
